branch_target_predictor: RTL



---
 rtl/branch_target_predictor.sv | 109 ++++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters,
// trained by EX-stage resolved outcomes, plus lookup/hit/mispredict statistics.
module branch_target_predictor #(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int CNT_WIDTH  = 2,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  input  logic                  lookup_en_i,
  output logic                  pred_taken_o,
  output logic [ADDR_WIDTH-1:0] pred_target_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic                  upd_is_jump_i,
  input  logic                  upd_taken_i,
  input  logic [ADDR_WIDTH-1:0] upd_target_i,
  input  logic                  upd_mispredict_i,
  output logic [STAT_WIDTH-1:0] stat_lookups_o,
  output logic [STAT_WIDTH-1:0] stat_hits_o,
  output logic [STAT_WIDTH-1:0] stat_mispred_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

  logic                  valid_q  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [CNT_WIDTH-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0]     lk_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 lk_hit;
  logic [IDX_W-1:0]     up_idx;
  logic [TAG_W-1:0]     up_tag;
  logic                 up_hit;
  logic                 up_taken;
  logic                 up_we;
  logic [CNT_WIDTH-1:0] up_cnt_cur;
  logic [CNT_WIDTH-1:0] up_cnt_nx;

  // Byte-offset bits of the PCs never select or tag an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  // Prediction is gated by rst_n so outputs are already 0 in the reset cycle.
  always_comb begin
    lk_idx        = lookup_pc_i[IDX_W+1:2];
    lk_tag        = lookup_pc_i[ADDR_WIDTH-1:IDX_W+2];
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = rst_n && lk_hit && cnt_q[lk_idx][CNT_WIDTH-1];
    pred_target_o = pred_taken_o ? target_q[lk_idx] : '0;
  end

  always_comb begin
    up_idx     = upd_pc_i[IDX_W+1:2];
    up_tag     = upd_pc_i[ADDR_WIDTH-1:IDX_W+2];
    up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_taken   = upd_taken_i || upd_is_jump_i;
    up_cnt_cur = cnt_q[up_idx];
    up_cnt_nx  = up_cnt_cur;
    if (upd_is_jump_i) begin
      up_cnt_nx = CNT_MAX;
    end else if (upd_taken_i) begin
      if (!up_hit)
        up_cnt_nx = CNT_WEAK;
      else if (up_cnt_cur != CNT_MAX)
        up_cnt_nx = up_cnt_cur + CNT_WIDTH'(1);
    end else if (up_cnt_cur != '0) begin
      up_cnt_nx = up_cnt_cur - CNT_WIDTH'(1);
    end
    // Not-taken misses leave the table alone; everything else writes the entry.
    up_we = upd_valid_i && (up_hit || up_taken);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      stat_lookups_o <= '0;
      stat_hits_o    <= '0;
      stat_mispred_o <= '0;
    end else begin
      if (up_we) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        cnt_q[up_idx]   <= up_cnt_nx;
        if (up_taken)
          target_q[up_idx] <= upd_target_i;
      end
      if (lookup_en_i)
        stat_lookups_o <= stat_lookups_o + STAT_WIDTH'(1);
      if (lookup_en_i && pred_taken_o)
        stat_hits_o <= stat_hits_o + STAT_WIDTH'(1);
      if (upd_valid_i && upd_mispredict_i)
        stat_mispred_o <= stat_mispred_o + STAT_WIDTH'(1);
    end
  end

endmodule
